// File: rtl/noc_out_port_alloc_pkg.sv
// Shared router definitions for the output-port allocator.
// Every router output instance and the input buffers use these defaults, so
// the credit count and the downstream buffer depth always agree.
//   - Default port count and port index constants (N, E, S, W, local).
//   - Default downstream input-buffer depth (initial credit count).
//   - Allocator FSM state encoding.
package noc_out_port_alloc_pkg;

  // Router port count and port indices
  localparam int unsigned NOC_N_PORTS = 5;
  localparam int unsigned PORT_N      = 0;
  localparam int unsigned PORT_E      = 1;
  localparam int unsigned PORT_S      = 2;
  localparam int unsigned PORT_W      = 3;
  localparam int unsigned PORT_L      = 4;

  // Depth of each downstream input buffer, in flits
  localparam int unsigned NOC_BUF_DEPTH = 4;

  // Allocator FSM states
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/noc_out_port_alloc_rr_pick.sv
// Round-robin priority picker (purely combinational).
// The search starts at the input just after i_ptr and wraps modulo N_REQ.
// Ports:
//   i_req   : request vector, one bit per input
//   i_ptr   : index of the most recently served input
//   o_pick  : one-hot winner, all-zero when nothing is requested
//   o_found : at least one request was present
module noc_out_port_alloc_rr_pick
  import noc_out_port_alloc_pkg::*;
#(
  parameter int unsigned N_REQ = NOC_N_PORTS,
  parameter int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic             o_found
);

  localparam int unsigned SH_W = PTR_W + 1;

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [SH_W-1:0]    w_shamt;
  int unsigned        w_sel;
  int unsigned        w_idx;

  always_comb begin
    // Rotate so that bit 0 of w_rot is input (ptr+1) mod N_REQ.
    w_shamt = {1'b0, i_ptr} + SH_W'(1);
    w_dbl   = {i_req, i_req};
    w_rot   = N_REQ'(w_dbl >> w_shamt);

    // Lowest set bit of the rotated vector wins; descending scan keeps the last hit.
    w_sel   = 0;
    o_found = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_sel   = unsigned'(j);
        o_found = 1'b1;
      end
    end

    // Undo the rotation to recover the absolute input index.
    w_idx = 32'(w_shamt) + w_sel;
    if (w_idx >= N_REQ) begin
      w_idx = w_idx - N_REQ;
    end

    o_pick = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_idx == unsigned'(i)) begin
        o_pick[i] = o_found;
      end
    end
  end

endmodule

// File: rtl/noc_out_port_alloc.sv
// Per-output-port wormhole allocator with round-robin arbitration and
// downstream credit flow control. One instance per router output port.
// Once an input wins the port, it keeps it until its tail flit has moved,
// regardless of request bubbles or other inputs.
// Ports:
//   i_clk        : rising-edge clock
//   i_rst        : synchronous active-high reset
//   i_req        : input i has a head flit routed to this output
//   i_tail       : head flit of input i is a tail flit (meaningful with i_req)
//   i_credit_in  : one-cycle pulse, downstream freed one buffer slot
//   o_gnt        : registered one-hot owner, zero when the port is free
//   o_flit_go    : a flit crosses the crossbar this cycle
//   o_credit_cnt : available downstream slots
//   o_credit_err : sticky, a credit arrived while the counter was full
module noc_out_port_alloc
  import noc_out_port_alloc_pkg::*;
#(
  parameter int unsigned N_REQ   = NOC_N_PORTS,
  parameter int unsigned CREDITS = NOC_BUF_DEPTH,
  parameter int unsigned CNT_W   = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_tail,
  input  logic             i_credit_in,
  output logic [N_REQ-1:0] o_gnt,
  output logic             o_flit_go,
  output logic [CNT_W-1:0] o_credit_cnt,
  output logic             o_credit_err
);

  localparam int unsigned      PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);
  // Pointer parked on the last input so input 0 wins first after reset
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N_REQ - 1);

  alloc_state_e     r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [PTR_W-1:0] r_owner, w_owner_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_credit_cnt, w_credit_cnt_nxt;
  logic             r_credit_err, w_credit_err_nxt;

  logic [N_REQ-1:0] w_pick;
  logic             w_found;
  logic [PTR_W-1:0] w_pick_idx;
  logic             w_flit_go;
  logic             w_owner_tail;

  noc_out_port_alloc_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_pick  (w_pick),
    .o_found (w_found)
  );

  // Binary index of the picked input, stored as the owner
  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick[i]) begin
        w_pick_idx = PTR_W'(i);
      end
    end
  end

  // r_gnt is one-hot or zero, so masking selects the owner's bits directly.
  assign w_flit_go    = (|(r_gnt & i_req)) && (r_credit_cnt != '0);
  assign w_owner_tail = |(r_gnt & i_tail);

  // Allocation FSM
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_gnt_nxt   = w_pick;
          w_owner_nxt = w_pick_idx;
          w_state_nxt = ST_LOCKED;
        end else begin
          w_gnt_nxt = '0;
        end
      end
      ST_LOCKED: begin
        // Release only once the tail flit has actually moved.
        if (w_flit_go && w_owner_tail) begin
          w_gnt_nxt   = '0;
          w_ptr_nxt   = r_owner;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Credit counter: a departing flit and a returning credit cancel out.
  always_comb begin
    w_credit_cnt_nxt = r_credit_cnt;
    w_credit_err_nxt = r_credit_err;
    unique case ({w_flit_go, i_credit_in})
      2'b10: w_credit_cnt_nxt = r_credit_cnt - CNT_W'(1);
      2'b01: begin
        if (r_credit_cnt == CRED_MAX) begin
          w_credit_err_nxt = 1'b1;
        end else begin
          w_credit_cnt_nxt = r_credit_cnt + CNT_W'(1);
        end
      end
      default: w_credit_cnt_nxt = r_credit_cnt;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_owner      <= '0;
      r_ptr        <= PTR_RST;
      r_credit_cnt <= CRED_MAX;
      r_credit_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_owner      <= w_owner_nxt;
      r_ptr        <= w_ptr_nxt;
      r_credit_cnt <= w_credit_cnt_nxt;
      r_credit_err <= w_credit_err_nxt;
    end
  end

  assign o_gnt        = r_gnt;
  assign o_flit_go    = w_flit_go;
  assign o_credit_cnt = r_credit_cnt;
  assign o_credit_err = r_credit_err;

`ifndef SYNTHESIS
  a_gnt_onehot0 : assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(r_gnt));
  a_credit_max  : assert property (@(posedge i_clk) disable iff (i_rst) r_credit_cnt <= CRED_MAX);
`endif

endmodule

// File: tb/tb_noc_out_port_alloc.sv
// Directed bench for noc_out_port_alloc. Each driven cycle pushes the
// hand-computed expected outputs for that cycle; a separate monitor pops and
// compares them just before the next rising edge.
module tb_noc_out_port_alloc;
  import noc_out_port_alloc_pkg::*;

  logic       clk;
  logic       rst;
  logic [4:0] req;
  logic [4:0] tail;
  logic       cin;
  logic [4:0] gnt;
  logic       go;
  logic [2:0] cnt;
  logic       err;

  typedef struct {
    logic [4:0] gnt;
    logic       go;
    logic [2:0] cnt;
    logic       err;
    logic       chk;
    string      nm;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  noc_out_port_alloc #(
    .N_REQ   (5),
    .CREDITS (4),
    .CNT_W   (3)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .i_tail       (tail),
    .i_credit_in  (cin),
    .o_gnt        (gnt),
    .o_flit_go    (go),
    .o_credit_cnt (cnt),
    .o_credit_err (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs and record what the outputs must be during it.
  task automatic cyc(input logic r, input logic [4:0] rq, input logic [4:0] tl, input logic ci,
                     input logic chk, input logic [4:0] eg, input logic ego,
                     input logic [2:0] ec, input logic ee, input string nm);
    exp_t e;
    @(negedge clk);
    rst  = r;
    req  = rq;
    tail = tl;
    cin  = ci;
    e.gnt = eg;
    e.go  = ego;
    e.cnt = ec;
    e.err = ee;
    e.chk = chk;
    e.nm  = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: samples 1 time unit before each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        if (e.chk) begin
          checks++;
          if (gnt !== e.gnt || go !== e.go || cnt !== e.cnt || err !== e.err) begin
            failures++;
            $display("FAIL %s: got gnt=%b go=%b cnt=%0d err=%b, want gnt=%b go=%b cnt=%0d err=%b",
                     e.nm, gnt, go, cnt, err, e.gnt, e.go, e.cnt, e.err);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] g;
    rst  = 1'b1;
    req  = '0;
    tail = '0;
    cin  = 1'b0;

    // Reset state
    cyc(1, 5'b00000, 5'b00000, 0, 0, 5'b00000, 0, 3'd0, 0, "rst");
    cyc(0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 3'd4, 0, "reset_state");

    // Single-flit packet from input 0
    cyc(0, 5'b00001, 5'b00001, 0, 1, 5'b00000, 0, 3'd4, 0, "t1_req_seen");
    cyc(0, 5'b00001, 5'b00001, 0, 1, 5'b00001, 1, 3'd4, 0, "t1_grant");
    cyc(0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 3'd3, 0, "t1_release");
    cyc(0, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 3'd3, 0, "t1_credit_back");

    // Round robin, all requesting, single-flit packets; credit returned on each transfer
    cyc(1, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 3'd4, 0, "t2_rst");
    cyc(0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 3'd4, 0, "t2_after_rst");
    for (int k = 0; k < 6; k++) begin
      g = 5'b00001 << (k % 5);
      cyc(0, 5'b11111, 5'b11111, 0, 1, 5'b00000, 0, 3'd4, 0, "t2_idle_gap");
      cyc(0, 5'b11111, 5'b11111, 1, 1, g, 1, 3'd4, 0, "t2_rr_grant");
    end
    cyc(0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 3'd4, 0, "t2_stop");

    // Wormhole: 3-flit packet from input 2 with a bubble, input 0 waiting
    cyc(0, 5'b00101, 5'b00000, 0, 1, 5'b00000, 0, 3'd4, 0, "t3_req_seen");
    cyc(0, 5'b00101, 5'b00000, 0, 1, 5'b00100, 1, 3'd4, 0, "t3_flit1");
    cyc(0, 5'b00001, 5'b00000, 0, 1, 5'b00100, 0, 3'd3, 0, "t3_bubble_hold");
    cyc(0, 5'b00101, 5'b00000, 0, 1, 5'b00100, 1, 3'd3, 0, "t3_flit2");
    cyc(0, 5'b00101, 5'b00100, 0, 1, 5'b00100, 1, 3'd2, 0, "t3_tail");
    cyc(0, 5'b00001, 5'b00001, 0, 1, 5'b00000, 0, 3'd1, 0, "t3_released");
    cyc(0, 5'b00001, 5'b00001, 0, 1, 5'b00001, 1, 3'd1, 0, "t3_input0_next");
    cyc(0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 3'd0, 0, "t3_idle_empty");
    for (int i = 0; i < 4; i++) begin
      cyc(0, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 3'(i), 0, "t3_refill");
    end
    cyc(0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 3'd4, 0, "t3_refilled");

    // Credit stall: 6-flit packet from input 1
    cyc(0, 5'b00010, 5'b00000, 0, 1, 5'b00000, 0, 3'd4, 0, "t4_req_seen");
    for (int i = 0; i < 4; i++) begin
      cyc(0, 5'b00010, 5'b00000, 0, 1, 5'b00010, 1, 3'(4 - i), 0, "t4_flit");
    end
    cyc(0, 5'b00010, 5'b00000, 0, 1, 5'b00010, 0, 3'd0, 0, "t4_stall_a");
    cyc(0, 5'b00010, 5'b00000, 0, 1, 5'b00010, 0, 3'd0, 0, "t4_stall_b");
    cyc(0, 5'b00010, 5'b00000, 1, 1, 5'b00010, 0, 3'd0, 0, "t4_credit1");
    cyc(0, 5'b00010, 5'b00000, 0, 1, 5'b00010, 1, 3'd1, 0, "t4_flit5");
    cyc(0, 5'b00010, 5'b00000, 1, 1, 5'b00010, 0, 3'd0, 0, "t4_credit2");
    cyc(0, 5'b00010, 5'b00010, 0, 1, 5'b00010, 1, 3'd1, 0, "t4_flit6_tail");
    cyc(0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 3'd0, 0, "t4_released");

    // Simultaneous flit_go and credit_in, then overflow credit
    cyc(0, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 3'd0, 0, "t5_credit_a");
    cyc(0, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 3'd1, 0, "t5_credit_b");
    cyc(0, 5'b00100, 5'b00000, 0, 1, 5'b00000, 0, 3'd2, 0, "t5_req_seen");
    cyc(0, 5'b00100, 5'b00000, 1, 1, 5'b00100, 1, 3'd2, 0, "t5_both_a");
    cyc(0, 5'b00100, 5'b00100, 1, 1, 5'b00100, 1, 3'd2, 0, "t5_both_tail");
    cyc(0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 3'd2, 0, "t5_cnt_kept");
    cyc(0, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 3'd2, 0, "t5_refill_a");
    cyc(0, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 3'd3, 0, "t5_refill_b");
    cyc(0, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 3'd4, 0, "t5_overflow");
    cyc(0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 3'd4, 1, "t5_err_set");
    cyc(0, 5'b01000, 5'b01000, 0, 1, 5'b00000, 0, 3'd4, 1, "t5_req3_seen");
    cyc(0, 5'b01000, 5'b01000, 0, 1, 5'b01000, 1, 3'd4, 1, "t5_grant3");
    cyc(0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 3'd3, 1, "t5_err_sticky");

    // Reset while input 3 is locked mid-packet
    cyc(0, 5'b01000, 5'b00000, 0, 1, 5'b00000, 0, 3'd3, 1, "t6_req_seen");
    cyc(0, 5'b01000, 5'b00000, 0, 1, 5'b01000, 1, 3'd3, 1, "t6_flit1");
    cyc(1, 5'b01000, 5'b00000, 0, 1, 5'b01000, 1, 3'd2, 1, "t6_rst_mid");
    cyc(0, 5'b11111, 5'b11111, 0, 1, 5'b00000, 0, 3'd4, 0, "t6_after_rst");
    cyc(0, 5'b11111, 5'b11111, 0, 1, 5'b00001, 1, 3'd4, 0, "t6_input0_first");
    cyc(0, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 3'd3, 0, "t6_release");

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
